// File: rtl/mms_pkg.sv
// Shared MMU types for the instruction/data TLB refill paths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: Sv39 VPN width, leaf PTE layout, ITLB refill FSM state encoding.
package mms_pkg;

   localparam int VPN_W = 27;
   localparam int MXLEN = 64;

   // Sv39 leaf PTE, MSB first
   typedef struct packed {
      logic [9:0]  reserved;
      logic [43:0] ppn;
      logic [1:0]  rsw;
      logic        d;
      logic        a;
      logic        g;
      logic        u;
      logic        x;
      logic        w;
      logic        r;
      logic        v;
   } pte_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      WAIT  = 2'd2,
      WRITE = 2'd3
   } itlb_refill_state_e;

endpackage

// File: rtl/itlb_victim_sel.sv
// Victim picker for a fully associative TLB: first invalid entry, else round-robin.
// Latency: victim is combinational from valid_i; pointer moves one cycle after advance_i.
// Backpressure: none; the owner decides when to advance.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   valid_i        per-entry valid bits
//   advance_i      step the round-robin pointer (use only when all entries are valid)
//   victim_o       selected entry index
//   all_valid_o    no invalid entry exists; victim_o is the pointer
module itlb_victim_sel #(
   parameter int N = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [N-1:0]         valid_i,
   input  logic                 advance_i,
   output logic [$clog2(N)-1:0] victim_o,
   output logic                 all_valid_o
);

   localparam int IDX_W = $clog2(N);

   logic [IDX_W-1:0] r_ptr;
   logic [IDX_W-1:0] w_first_inv;
   logic             w_found_inv;

   // Scan from the top down so the lowest invalid index is the last one kept.
   always_comb begin
      w_first_inv = '0;
      w_found_inv = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (!valid_i[i]) begin
            w_first_inv = IDX_W'(i);
            w_found_inv = 1'b1;
         end
      end
   end

   assign all_valid_o = !w_found_inv;
   assign victim_o    = w_found_inv ? w_first_inv : r_ptr;

   // N is a power of two, so the natural wrap of the adder is the modulo.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_ptr <= '0;
      end else if (advance_i) begin
         r_ptr <= r_ptr + IDX_W'(1);
      end
   end

endmodule

// File: rtl/itlb_refill_ctrl.sv
// ITLB refill: takes a lookup miss, walks it through the PTW, writes one victim entry.
// Latency: accept -> REQ -> WAIT -> WRITE, write 2 cycles after the PTW response (4 cycles minimum).
// Backpressure: one refill outstanding; miss_ready_o low while busy or flushing, request held until ptw_req_ready_i.
// Ports:
//   clk_i, rst_i                     clock, asynchronous active-high reset
//   miss_*                           miss handshake from the lookup stage
//   ptw_req_* / ptw_resp_*           walk request (valid/ready) and single-cycle response
//   flush_i                          invalidate all entries, abort any walk in flight
//   wr_en_o, pte_wr_o, tag_wr_o      one-hot write port into the entry array
//   entry_valid_o                    per-entry valid bits owned here
//   refill_done_o, refill_fault_o    completion / fault pulses
//   busy_o                           refill in progress
module itlb_refill_ctrl #(
   parameter int TLB_ENTRY_NUM = 8,
   parameter int MXLEN         = mms_pkg::MXLEN,
   parameter int VPN_W         = mms_pkg::VPN_W
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     miss_valid_i,
   input  logic [VPN_W-1:0]         miss_vpn_i,
   output logic                     miss_ready_o,
   output logic                     ptw_req_valid_o,
   input  logic                     ptw_req_ready_i,
   output logic [VPN_W-1:0]         ptw_req_vpn_o,
   input  logic                     ptw_resp_valid_i,
   input  logic [MXLEN-1:0]         ptw_resp_pte_i,
   input  logic                     ptw_resp_fault_i,
   input  logic                     flush_i,
   output logic [TLB_ENTRY_NUM-1:0] wr_en_o,
   output logic [MXLEN-1:0]         pte_wr_o,
   output logic [VPN_W-1:0]         tag_wr_o,
   output logic [TLB_ENTRY_NUM-1:0] entry_valid_o,
   output logic                     refill_done_o,
   output logic                     refill_fault_o,
   output logic                     busy_o
);

   import mms_pkg::*;

   localparam int IDX_W = $clog2(TLB_ENTRY_NUM);

   itlb_refill_state_e r_state;
   itlb_refill_state_e w_state_nxt;

   logic [VPN_W-1:0]         r_vpn;
   logic [MXLEN-1:0]         r_pte;
   logic                     r_abort;
   logic [TLB_ENTRY_NUM-1:0] r_valid;

   logic                     w_abort_nxt;
   logic                     w_latch_vpn;
   logic                     w_latch_pte;
   logic                     w_set_valid;
   logic                     w_advance;
   logic [IDX_W-1:0]         w_victim;
   logic                     w_all_valid;
   logic [TLB_ENTRY_NUM-1:0] w_victim_oh;

   itlb_victim_sel #(
      .N (TLB_ENTRY_NUM)
   ) u_victim_sel (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .valid_i     (r_valid),
      .advance_i   (w_advance),
      .victim_o    (w_victim),
      .all_valid_o (w_all_valid)
   );

   assign w_victim_oh = TLB_ENTRY_NUM'(1) << w_victim;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_abort_nxt     = r_abort;
      w_latch_vpn     = 1'b0;
      w_latch_pte     = 1'b0;
      w_set_valid     = 1'b0;
      w_advance       = 1'b0;
      miss_ready_o    = 1'b0;
      ptw_req_valid_o = 1'b0;
      ptw_req_vpn_o   = '0;
      wr_en_o         = '0;
      pte_wr_o        = '0;
      tag_wr_o        = '0;
      refill_done_o   = 1'b0;
      refill_fault_o  = 1'b0;

      case (r_state)
         IDLE: begin
            miss_ready_o = !flush_i;
            if (miss_valid_i && !flush_i) begin
               w_latch_vpn = 1'b1;
               w_abort_nxt = 1'b0;
               w_state_nxt = REQ;
            end
         end

         REQ: begin
            ptw_req_valid_o = 1'b1;
            ptw_req_vpn_o   = r_vpn;
            if (flush_i) begin
               w_abort_nxt = 1'b1;
            end
            if (ptw_req_ready_i) begin
               w_state_nxt = WAIT;
            end
         end

         WAIT: begin
            if (flush_i) begin
               w_abort_nxt = 1'b1;
            end
            // A flush landing on the response cycle aborts just like an earlier one:
            // the entries it cleared must not be refilled with a pre-flush walk.
            if (ptw_resp_valid_i) begin
               if (ptw_resp_fault_i || r_abort || flush_i) begin
                  refill_fault_o = ptw_resp_fault_i && !r_abort && !flush_i;
                  w_state_nxt    = IDLE;
               end else begin
                  w_latch_pte = 1'b1;
                  w_state_nxt = WRITE;
               end
            end
         end

         WRITE: begin
            pte_wr_o    = r_pte;
            tag_wr_o    = r_vpn;
            w_state_nxt = IDLE;
            if (!flush_i) begin
               wr_en_o       = w_victim_oh;
               w_set_valid   = 1'b1;
               refill_done_o = 1'b1;
               // Pointer only moves when it was actually used as the victim.
               w_advance     = w_all_valid;
            end
         end

         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_vpn   <= '0;
         r_pte   <= '0;
         r_abort <= 1'b0;
         r_valid <= '0;
      end else begin
         r_abort <= w_abort_nxt;
         if (w_latch_vpn) begin
            r_vpn <= miss_vpn_i;
         end
         if (w_latch_pte) begin
            r_pte <= ptw_resp_pte_i;
         end
         if (flush_i) begin
            r_valid <= '0;
         end else if (w_set_valid) begin
            r_valid <= r_valid | w_victim_oh;
         end
      end
   end

   assign entry_valid_o = r_valid;
   assign busy_o        = (r_state != IDLE);

endmodule

// File: tb/tb_itlb_refill_ctrl.sv
// Self-checking bench for itlb_refill_ctrl: directed scenarios then randomized refills
// against a transaction-level model of the valid bits and replacement pointer.
module tb_itlb_refill_ctrl;

   localparam int N     = 8;
   localparam int MXLEN = 64;
   localparam int VPN_W = 27;

   logic             clk;
   logic             rst;
   logic             miss_valid_i;
   logic [VPN_W-1:0] miss_vpn_i;
   logic             miss_ready_o;
   logic             ptw_req_valid_o;
   logic             ptw_req_ready_i;
   logic [VPN_W-1:0] ptw_req_vpn_o;
   logic             ptw_resp_valid_i;
   logic [MXLEN-1:0] ptw_resp_pte_i;
   logic             ptw_resp_fault_i;
   logic             flush_i;
   logic [N-1:0]     wr_en_o;
   logic [MXLEN-1:0] pte_wr_o;
   logic [VPN_W-1:0] tag_wr_o;
   logic [N-1:0]     entry_valid_o;
   logic             refill_done_o;
   logic             refill_fault_o;
   logic             busy_o;

   int checks;
   int failures;

   // Reference state: which entries hold a translation, and the replacement pointer.
   bit model_valid [N];
   int model_ptr;

   itlb_refill_ctrl #(
      .TLB_ENTRY_NUM (N),
      .MXLEN         (MXLEN),
      .VPN_W         (VPN_W)
   ) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .miss_valid_i     (miss_valid_i),
      .miss_vpn_i       (miss_vpn_i),
      .miss_ready_o     (miss_ready_o),
      .ptw_req_valid_o  (ptw_req_valid_o),
      .ptw_req_ready_i  (ptw_req_ready_i),
      .ptw_req_vpn_o    (ptw_req_vpn_o),
      .ptw_resp_valid_i (ptw_resp_valid_i),
      .ptw_resp_pte_i   (ptw_resp_pte_i),
      .ptw_resp_fault_i (ptw_resp_fault_i),
      .flush_i          (flush_i),
      .wr_en_o          (wr_en_o),
      .pte_wr_o         (pte_wr_o),
      .tag_wr_o         (tag_wr_o),
      .entry_valid_o    (entry_valid_o),
      .refill_done_o    (refill_done_o),
      .refill_fault_o   (refill_fault_o),
      .busy_o           (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [N-1:0] model_vec();
      logic [N-1:0] v;
      v = '0;
      for (int i = 0; i < N; i++) v[i] = model_valid[i];
      return v;
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < N; i++) model_valid[i] = 1'b0;
   endfunction

   // Lowest free slot if there is one, otherwise the replacement pointer.
   function automatic int model_victim();
      for (int i = 0; i < N; i++) if (!model_valid[i]) return i;
      return model_ptr;
   endfunction

   function automatic bit model_full();
      for (int i = 0; i < N; i++) if (!model_valid[i]) return 1'b0;
      return 1'b1;
   endfunction

   // fmode: 0 no flush, 1 flush on first WAIT cycle, 2 flush on the WRITE cycle
   task automatic refill(input logic [VPN_W-1:0] vpn, input logic [MXLEN-1:0] pte,
                         input int rdy_dly, input int rsp_dly, input bit fault, input int fmode);
      int n;
      int v;
      bit aborted;
      bit full;
      logic [N-1:0] exp_oh;
      aborted = 1'b0;
      n = 0;
      while (miss_ready_o !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk("miss_ready_idle", miss_ready_o, 1);
      miss_valid_i = 1'b1;
      miss_vpn_i   = vpn;
      tick();
      miss_valid_i = 1'b0;
      miss_vpn_i   = VPN_W'($urandom);
      for (int i = 0; i < rdy_dly; i++) begin
         #1;
         chk("req_valid_hold", ptw_req_valid_o, 1);
         chk("req_vpn_hold", ptw_req_vpn_o, vpn);
         tick();
      end
      ptw_req_ready_i = 1'b1;
      #1;
      chk("req_valid", ptw_req_valid_o, 1);
      chk("req_vpn", ptw_req_vpn_o, vpn);
      tick();
      ptw_req_ready_i = 1'b0;
      for (int i = 0; i < rsp_dly; i++) begin
         if (fmode == 1 && i == 0) begin
            flush_i = 1'b1;
            aborted = 1'b1;
         end
         #1;
         chk("wait_no_write", wr_en_o, 0);
         chk("wait_busy", busy_o, 1);
         tick();
         if (flush_i) model_clear();
         flush_i = 1'b0;
      end
      ptw_resp_valid_i = 1'b1;
      ptw_resp_pte_i   = pte;
      ptw_resp_fault_i = fault;
      #1;
      chk("fault_pulse", refill_fault_o, fault && !aborted);
      chk("resp_no_done", refill_done_o, 0);
      tick();
      ptw_resp_valid_i = 1'b0;
      ptw_resp_fault_i = 1'b0;
      ptw_resp_pte_i   = MXLEN'({$urandom, $urandom});
      if (fault || aborted) begin
         #1;
         chk("abort_idle", busy_o, 0);
         chk("abort_miss_ready", miss_ready_o, 1);
         chk("abort_no_write", wr_en_o, 0);
         chk("abort_no_fault", refill_fault_o, 0);
         chk("abort_valid", entry_valid_o, model_vec());
      end else begin
         if (fmode == 2) flush_i = 1'b1;
         v = model_victim();
         full = model_full();
         exp_oh = (fmode == 2) ? '0 : N'(1 << v);
         #1;
         chk("write_en", wr_en_o, exp_oh);
         chk("write_done", refill_done_o, fmode != 2);
         chk("write_no_fault", refill_fault_o, 0);
         if (fmode != 2) begin
            chk("write_pte", pte_wr_o, pte);
            chk("write_tag", tag_wr_o, vpn);
         end
         tick();
         flush_i = 1'b0;
         if (fmode == 2) begin
            model_clear();
         end else begin
            model_valid[v] = 1'b1;
            if (full) model_ptr = (model_ptr + 1) % N;
         end
         #1;
         chk("post_valid", entry_valid_o, model_vec());
         chk("post_idle", busy_o, 0);
         chk("post_no_write", wr_en_o, 0);
      end
   endtask

   initial begin
      int r;
      int rdy;
      int rsp;
      int fm;
      bit flt;
      logic [VPN_W-1:0] vpn;
      logic [MXLEN-1:0] pte;
      checks = 0;
      failures = 0;
      model_clear();
      model_ptr = 0;
      rst = 1'b1;
      miss_valid_i = 1'b0;
      miss_vpn_i = '0;
      ptw_req_ready_i = 1'b0;
      ptw_resp_valid_i = 1'b0;
      ptw_resp_pte_i = '0;
      ptw_resp_fault_i = 1'b0;
      flush_i = 1'b0;
      #3;
      chk("rst_miss_ready", miss_ready_o, 1);
      chk("rst_req_valid", ptw_req_valid_o, 0);
      chk("rst_req_vpn", ptw_req_vpn_o, 0);
      chk("rst_wr_en", wr_en_o, 0);
      chk("rst_pte", pte_wr_o, 0);
      chk("rst_tag", tag_wr_o, 0);
      chk("rst_valid", entry_valid_o, 0);
      chk("rst_done", refill_done_o, 0);
      chk("rst_fault", refill_fault_o, 0);
      chk("rst_busy", busy_o, 0);
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Basic refill: first write lands in entry 0.
      refill(27'h1234, 64'hABCD, 0, 3, 1'b0, 0);
      chk("basic_valid", entry_valid_o, 8'h01);

      // Flush in IDLE: miss refused that cycle, entries cleared, pointer kept.
      miss_valid_i = 1'b1;
      miss_vpn_i = 27'h777;
      flush_i = 1'b1;
      #1;
      chk("flush_idle_ready", miss_ready_o, 0);
      tick();
      flush_i = 1'b0;
      miss_valid_i = 1'b0;
      model_clear();
      #1;
      chk("flush_idle_not_busy", busy_o, 0);
      chk("flush_idle_valid", entry_valid_o, 0);

      // Fill all entries, then three replacements wrap through 0, 1, 2.
      for (int i = 0; i < N + 3; i++) begin
         refill(VPN_W'(32'h100 + i), MXLEN'(64'hF000 + i), i % 2, 0, 1'b0, 0);
         chk("fill_order", tag_wr_o, 0);
      end
      chk("fill_full", entry_valid_o, 8'hFF);

      refill(27'h0BAD, 64'h5555, 1, 1, 1'b1, 0);
      refill(27'h0F1A, 64'h6666, 0, 2, 1'b0, 1);
      chk("flush_wait_valid", entry_valid_o, 0);
      refill(27'h0AAA, 64'h7777, 0, 0, 1'b0, 0);
      refill(27'h0BBB, 64'h8888, 0, 1, 1'b0, 2);
      chk("flush_write_valid", entry_valid_o, 0);

      for (int t = 0; t < 40; t++) begin
         vpn = VPN_W'($urandom);
         pte = MXLEN'({$urandom, $urandom});
         rdy = $urandom_range(0, 3);
         rsp = $urandom_range(0, 3);
         flt = ($urandom_range(0, 5) == 0);
         r = $urandom_range(0, 9);
         fm = (r == 8) ? 1 : (r == 9) ? 2 : 0;
         if (fm == 1 && rsp == 0) rsp = 1;
         refill(vpn, pte, rdy, rsp, flt, fm);
      end

      // Backpressure then asynchronous reset while in REQ.
      vpn = 27'h2ABCDEF;
      miss_valid_i = 1'b1;
      miss_vpn_i = vpn;
      tick();
      miss_valid_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_req_valid", ptw_req_valid_o, 1);
         chk("bp_req_vpn", ptw_req_vpn_o, vpn);
         tick();
      end
      #1;
      rst = 1'b1;
      #1;
      chk("arst_req_valid", ptw_req_valid_o, 0);
      chk("arst_req_vpn", ptw_req_vpn_o, 0);
      chk("arst_busy", busy_o, 0);
      chk("arst_miss_ready", miss_ready_o, 1);
      chk("arst_valid", entry_valid_o, 0);
      model_clear();
      model_ptr = 0;
      tick();
      rst = 1'b0;
      tick();
      refill(27'h0321, 64'h9999, 0, 0, 1'b0, 0);
      chk("after_rst_valid", entry_valid_o, 8'h01);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/itlb_refill_ctrl.md
Name: itlb_refill_ctrl

Overview:
Refill controller on the write side of the ITLB entry array. It accepts a miss from the ITLB lookup and requests a translation from the page-table walker (PTW). It selects a victim entry and drives the array's one-hot write enable with the returned PTE and VPN tag. It also owns the per-entry valid bits and handles flush.

Parameters:
TLB_ENTRY_NUM, 8, number of ITLB entries; must be a power of two and at least 2
MXLEN, 64, PTE width in bits
VPN_W, 27, virtual page number width (Sv39)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
miss_valid_i  in  1  lookup missed; miss_vpn_i is valid
miss_vpn_i  in  VPN_W  VPN that missed
miss_ready_o  out  1  controller can accept a miss
ptw_req_valid_o  out  1  walk request valid
ptw_req_ready_i  in  1  PTW accepts the request
ptw_req_vpn_o  out  VPN_W  VPN to walk
ptw_resp_valid_i  in  1  walk response valid; single cycle, always accepted
ptw_resp_pte_i  in  MXLEN  leaf PTE
ptw_resp_fault_i  in  1  walk faulted
flush_i  in  1  invalidate all entries
wr_en_o  out  TLB_ENTRY_NUM  one-hot write enable to the entry array
pte_wr_o  out  MXLEN  PTE write data
tag_wr_o  out  VPN_W  tag write data
entry_valid_o  out  TLB_ENTRY_NUM  per-entry valid bits
refill_done_o  out  1  one-cycle pulse when an entry is written
refill_fault_o  out  1  one-cycle pulse on a walk fault
busy_o  out  1  state is not IDLE

Behaviour:
- Reset (asynchronous, active-high):
  - State is IDLE.
  - All outputs are 0, except miss_ready_o, which is 1.
  - Valid bits are 0, round-robin pointer is 0, latched VPN/PTE are 0.
- FSM states: IDLE, REQ, WAIT, WRITE.
- IDLE:
  - miss_ready_o = !flush_i.
  - On miss_valid_i && miss_ready_o: latch the VPN, clear the abort flag, go to REQ.
- REQ:
  - ptw_req_valid_o = 1 and ptw_req_vpn_o = latched VPN; both are held stable until the handshake.
  - On ptw_req_ready_i: go to WAIT.
- WAIT:
  - On ptw_resp_valid_i with fault or abort set: go to IDLE with no write.
  - refill_fault_o pulses in that same cycle only if fault is set and abort is clear.
  - On ptw_resp_valid_i with no fault and abort clear: latch the PTE, go to WRITE.
- WRITE (exactly one cycle):
  - wr_en_o = onehot(victim); pte_wr_o = latched PTE; tag_wr_o = latched VPN.
  - Set valid[victim]; refill_done_o = 1; go to IDLE.
- Outside WRITE, wr_en_o is 0 and pte_wr_o/tag_wr_o are 0.
- Miss-to-write latency: 2 cycles after the PTW response (latch cycle, then the WRITE cycle). Minimum from miss accept is 4 cycles with ready and response immediate.
- Victim selection, computed combinationally in WRITE from the current valid bits:
  - If any entry is invalid, the victim is the lowest-index invalid entry and the pointer is unchanged.
  - Otherwise the victim is the pointer, and the pointer advances by 1 mod TLB_ENTRY_NUM.
- Flush:
  - Clears all valid bits next cycle.
  - In REQ or WAIT: sets abort. The PTW handshake still completes, but nothing is written and neither pulse fires.
  - In WRITE: flush wins. wr_en_o is forced to 0, no valid bit is set, refill_done_o = 0, go to IDLE.
  - In IDLE: a miss is not accepted in that cycle.
  - The pointer is not reset by flush.
- A response arriving outside WAIT is ignored.
- At most one refill is outstanding; no queuing.
- wr_en_o is always zero or one-hot; refill_done_o and refill_fault_o are never asserted together.

Decomposition:
- mms_pkg holds:
  - pte_t (existing)
  - itlb_refill_state_e (IDLE/REQ/WAIT/WRITE)
  - VPN_W constant for Sv39
- Sub-module itlb_victim_sel: combinational priority search for the first invalid entry, plus the round-robin pointer register with an advance input. It is reusable for the DTLB.

Test Plan:
1. Reset and basic refill:
   - Stimulus: after reset, miss VPN=0x1234; ptw_req_ready_i=1 immediately; response PTE=0xABCD after 3 cycles.
   - Response: wr_en_o=0x01, pte_wr_o=0xABCD, tag_wr_o=0x1234, refill_done_o pulse, entry_valid_o=0x01.
2. Fill then replace:
   - Stimulus: 8 successful refills, then 3 more.
   - Response: the first 8 write entries 0..7 in order; the next 3 write entries 0, 1, 2 (round-robin).
3. Fault:
   - Stimulus: response with ptw_resp_fault_i=1.
   - Response: refill_fault_o pulses once, wr_en_o stays 0, entry_valid_o unchanged, back in IDLE next cycle.
4. Flush in WAIT:
   - Stimulus: flush_i asserted while waiting; response arrives 2 cycles later.
   - Response: entry_valid_o=0, no write, no pulse, miss_ready_o=1 after the response.
5. Flush in WRITE:
   - Stimulus: flush_i coincident with the WRITE cycle.
   - Response: wr_en_o=0, entry_valid_o=0, refill_done_o=0.
6. Backpressure and reset mid-operation:
   - Stimulus: ptw_req_ready_i held low for 5 cycles, then rst_i asserted in REQ.
   - Response: ptw_req_valid_o and the VPN stay stable throughout; on reset, outputs clear immediately (asynchronously) and miss_ready_o=1.
